// File: rtl/aes_round_sequencer.sv
// Load/round/unload sequencer for one iterative AES block between the stream FSM and the round datapath.
// Optional cycle counter enabled by defining AES_SEQ_PERF_CNT_EN.
module aes_round_sequencer #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [1:0]                   key_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            in_data,
    output logic                         dp_load,
    output logic [$clog2(NUM_WORDS)-1:0] dp_word_idx,
    output logic [WORD_W-1:0]            dp_data,
    input  logic                         rk_valid,
    output logic                         dp_round_en,
    output logic [3:0]                   dp_round_idx,
    output logic                         dp_first,
    output logic                         dp_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  cycles
);

    localparam int IW = $clog2(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_word_idx;
    logic [IW-1:0]     r_load_idx;
    logic [3:0]        r_round;
    logic [3:0]        r_nr;
    logic              r_dp_load;
    logic [WORD_W-1:0] r_dp_data;
    logic              r_done;
    logic              r_err;

    logic              w_round_en;
    logic              w_last_word;
    logic              w_accept_start;

    assign w_round_en     = (r_state == S_ROUND) && rk_valid;
    assign w_last_word    = (r_word_idx == IW'(NUM_WORDS - 1));
    assign w_accept_start = (r_state == S_IDLE) && start && (key_len != 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_word_idx <= '0;
            r_load_idx <= '0;
            r_round    <= '0;
            r_nr       <= '0;
            r_dp_load  <= 1'b0;
            r_dp_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_word_idx <= '0;
            r_load_idx <= '0;
            r_round    <= '0;
            r_nr       <= '0;
            r_dp_load  <= 1'b0;
            r_dp_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_dp_load <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_nr       <= 4'd10 + {1'b0, key_len, 1'b0};
                            r_word_idx <= '0;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        // Keep the accepted index so dp_word_idx matches the delayed dp_load.
                        r_dp_load  <= 1'b1;
                        r_dp_data  <= in_data;
                        r_load_idx <= r_word_idx;
                        if (w_last_word) begin
                            r_word_idx <= '0;
                            r_round    <= '0;
                            r_state    <= S_ROUND;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    if (rk_valid) begin
                        if (r_round == r_nr) begin
                            r_round <= '0;
                            r_state <= S_UNLOAD;
                        end else begin
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (w_last_word) begin
                            r_word_idx <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AES_SEQ_PERF_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (clear) begin
            r_cycles <= '0;
        end else if (w_accept_start) begin
            r_cycles <= '0;
        end else if ((r_state == S_LOAD || r_state == S_ROUND || r_state == S_UNLOAD)
                     && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`else
    assign cycles = '0;
`endif

    assign in_ready     = (r_state == S_LOAD);
    assign out_valid    = (r_state == S_UNLOAD);
    assign busy         = (r_state != S_IDLE);
    assign dp_round_en  = w_round_en;
    assign dp_round_idx = r_round;
    assign dp_first     = w_round_en && (r_round == 4'd0);
    assign dp_last      = w_round_en && (r_round == r_nr);
    assign dp_word_idx  = (r_state == S_UNLOAD) ? r_word_idx : r_load_idx;
    assign dp_load      = r_dp_load;
    assign dp_data      = r_dp_data;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: table-driven block runs, randomized runs against a phase-length model,
// and hand sequences for error start, reset state and clear mid-round.
module tb_aes_round_sequencer;

    localparam int MAXC = 256;
`ifdef AES_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, clear, start;
    logic [1:0]  key_len;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        dp_load;
    logic [1:0]  dp_word_idx;
    logic [31:0] dp_data;
    logic        rk_valid, dp_round_en, dp_first, dp_last;
    logic [3:0]  dp_round_idx;
    logic        out_valid, out_ready, busy, done, err;
    logic [31:0] cycles;

    always #5 clk = ~clk;

    aes_round_sequencer #(.WORD_W(32), .NUM_WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .key_len(key_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_load(dp_load), .dp_word_idx(dp_word_idx), .dp_data(dp_data),
        .rk_valid(rk_valid), .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
        .dp_first(dp_first), .dp_last(dp_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .cycles(cycles)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit          s_iv[MAXC];
    bit          s_rk[MAXC];
    bit          s_or[MAXC];
    logic [31:0] s_w[4];

    typedef struct {
        logic [1:0]  kl;
        bit          rk_alt;
        int          hold2;
        int          exp_done;
        logic [31:0] exp_cyc;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ideal();
        for (int i = 0; i < MAXC; i++) begin
            s_iv[i] = 1'b1;
            s_rk[i] = 1'b1;
            s_or[i] = 1'b1;
        end
        s_w[0] = 32'h00112233;
        s_w[1] = 32'h44556677;
        s_w[2] = 32'h8899AABB;
        s_w[3] = 32'hCCDDEEFF;
    endtask

    task automatic fill_random(input int piv, input int prk, input int por);
        for (int i = 0; i < MAXC; i++) begin
            s_iv[i] = (i >= 120) || ($urandom_range(0, 99) < piv);
            s_rk[i] = (i >= 120) || ($urandom_range(0, 99) < prk);
            s_or[i] = (i >= 120) || ($urandom_range(0, 99) < por);
        end
        for (int i = 0; i < 4; i++) s_w[i] = $urandom();
    endtask

    // Reference: phase lengths follow from how many cycles each handshake stream needs to
    // deliver 4 loads, Nr+1 round keys and 4 unloads; every output is derived from those windows.
    task automatic run_block(input logic [1:0] kl, output int done_at, output logic [31:0] cyc_end);
        int nr, c, n, t_l, t_r, t_u, dcyc, ldn, rn, un, pend_idx;
        bit pend_ld, in_load, in_round, in_unl, en_e;
        nr = 10 + 2 * int'(kl);
        c = 1; n = 0;
        while (n < 4)      begin if (s_iv[c]) n++; c++; end
        t_l = c - 1; n = 0;
        while (n < nr + 1) begin if (s_rk[c]) n++; c++; end
        t_r = c - 1; n = 0;
        while (n < 4)      begin if (s_or[c]) n++; c++; end
        t_u = c - 1;
        dcyc = t_u + 2;
        done_at = -1;
        ldn = 0; rn = 0; un = 0; pend_ld = 1'b0; pend_idx = 0;
        for (int cy = 0; cy <= dcyc + 1; cy++) begin
            step();
            clear = 1'b0;
            if (cy == 0) begin
                start   = 1'b1;
                key_len = kl;
            end else begin
                start   = (cy <= t_u + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                key_len = 2'($urandom_range(0, 3));
            end
            in_load  = (cy >= 1) && (cy <= t_l);
            in_round = (cy > t_l) && (cy <= t_r);
            in_unl   = (cy > t_r) && (cy <= t_u);
            in_valid = in_load ? s_iv[cy] : 1'($urandom_range(0, 1));
            in_data  = (in_load && ldn < 4) ? s_w[ldn] : $urandom();
            rk_valid = s_rk[cy];
            out_ready = s_or[cy];
            @(negedge clk);
            en_e = in_round && s_rk[cy];
            chk("in_ready", 32'(in_ready), 32'(in_load));
            chk("busy", 32'(busy), 32'((cy >= 1) && (cy <= t_u + 1)));
            chk("dp_load", 32'(dp_load), 32'(pend_ld));
            if (pend_ld) begin
                chk("load_idx", 32'(dp_word_idx), 32'(pend_idx));
                chk("load_data", dp_data, s_w[pend_idx]);
            end
            chk("round_en", 32'(dp_round_en), 32'(en_e));
            if (in_round) chk("round_idx", 32'(dp_round_idx), 32'(rn));
            chk("dp_first", 32'(dp_first), 32'(en_e && rn == 0));
            chk("dp_last", 32'(dp_last), 32'(en_e && rn == nr));
            chk("out_valid", 32'(out_valid), 32'(in_unl));
            if (in_unl) chk("unload_idx", 32'(dp_word_idx), 32'(un));
            chk("done", 32'(done), 32'(cy == dcyc));
            chk("err", 32'(err), 32'd0);
            if (cy >= 1) chk("cycles", cycles, PERF ? 32'((cy - 1 < t_u) ? cy - 1 : t_u) : 32'd0);
            if (done && done_at < 0) done_at = cy;
            pend_ld = in_load && s_iv[cy];
            pend_idx = ldn;
            if (pend_ld) ldn++;
            if (en_e) rn++;
            if (in_unl && s_or[cy]) un++;
        end
        cyc_end = cycles;
        step();
        start = 1'b0; in_valid = 1'b0; rk_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          done_at;
        logic [31:0] cyc_end;
        int          nr, u0;

        tbl[0] = '{kl: 2'd0, rk_alt: 1'b0, hold2: 0, exp_done: 21, exp_cyc: 32'd19};
        tbl[1] = '{kl: 2'd1, rk_alt: 1'b0, hold2: 0, exp_done: 23, exp_cyc: 32'd21};
        tbl[2] = '{kl: 2'd2, rk_alt: 1'b1, hold2: 0, exp_done: 39, exp_cyc: 32'd37};
        tbl[3] = '{kl: 2'd0, rk_alt: 1'b0, hold2: 5, exp_done: 26, exp_cyc: 32'd24};

        reset_n = 1'b0; clear = 1'b0; start = 1'b0; key_len = 2'd0;
        in_valid = 1'b0; in_data = '0; rk_valid = 1'b1; out_ready = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_dp_load", 32'(dp_load), 32'd0);
        chk("rst_dp_data", dp_data, 32'd0);
        chk("rst_idx", 32'(dp_word_idx), 32'd0);
        chk("rst_round_en", 32'(dp_round_en), 32'd0);
        chk("rst_round_idx", 32'(dp_round_idx), 32'd0);
        chk("rst_first_last", 32'({dp_first, dp_last}), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        step();
        reset_n = 1'b1;
        rk_valid = 1'b0;
        step();

        for (int t = 0; t < 4; t++) begin
            fill_ideal();
            nr = 10 + 2 * int'(tbl[t].kl);
            if (tbl[t].rk_alt)
                for (int i = 5; i < MAXC; i++) s_rk[i] = ((i - 5) % 2 == 0);
            if (tbl[t].hold2 > 0) begin
                u0 = nr + 6;
                for (int i = 0; i < tbl[t].hold2; i++) s_or[u0 + 2 + i] = 1'b0;
            end
            run_block(tbl[t].kl, done_at, cyc_end);
            chk("tbl_done_latency", 32'(done_at), 32'(tbl[t].exp_done));
            chk("tbl_cycles", cyc_end, PERF ? tbl[t].exp_cyc : 32'd0);
        end

        // Reserved key length: error pulse only, no block started.
        step();
        start = 1'b1; key_len = 2'd3;
        step();
        start = 1'b0; key_len = 2'd0;
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_in_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("err_busy_after", 32'(busy), 32'd0);

        // Clear at round 5 together with start: back to IDLE, no done.
        fill_ideal();
        step();
        start = 1'b1; key_len = 2'd0; in_valid = 1'b1; rk_valid = 1'b1; out_ready = 1'b1;
        for (int cy = 1; cy <= 10; cy++) begin
            step();
            start = 1'b0;
            in_data = (cy <= 4) ? s_w[cy - 1] : 32'hDEADBEEF;
        end
        chk("clr_round5", 32'(dp_round_idx), 32'd5);
        clear = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_round_en", 32'(dp_round_en), 32'd0);
        chk("clr_round_idx", 32'(dp_round_idx), 32'd0);
        chk("clr_cycles", cycles, 32'd0);
        for (int cy = 0; cy < 25; cy++) begin
            step();
            @(negedge clk);
            chk("clr_no_done", 32'({done, busy}), 32'd0);
        end
        in_valid = 1'b0; rk_valid = 1'b0; out_ready = 1'b0;
        run_block(2'd0, done_at, cyc_end);
        chk("clr_next_done", 32'(done_at), 32'd21);

        for (int r = 0; r < 6; r++) begin
            fill_random(70, 60, 70);
            run_block(2'($urandom_range(0, 2)), done_at, cyc_end);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
